// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: bus types shared by the CPU-side ibus/dbus ports, the memory-side
// cbus port and the bridge internals, plus request normalisation helpers.
package mem_bridge_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } mlen_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2
  } axi_burst_type_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef struct packed {
    logic            valid;
    logic            is_write;
    msize_t          size;
    addr_t           addr;
    strobe_t         strobe;
    word_t           data;
    mlen_t           len;
    axi_burst_type_t burst;
  } cbus_req_t;

  typedef struct packed {
    logic  ready;
    logic  last;
    word_t data;
  } cbus_resp_t;

  // Transaction fields held by the bridge while a memory access is in flight
  typedef struct packed {
    logic    is_write;
    msize_t  size;
    addr_t   addr;
    strobe_t strobe;
    word_t   data;
  } xact_t;

  // One-hot grant encoding: bit 1 = dbus, bit 0 = ibus
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IBUS = 2'b01;
  localparam logic [1:0] GNT_DBUS = 2'b10;

  // Instruction fetches are always 32-bit reads
  function automatic xact_t ibus_to_xact(input addr_t addr);
    xact_t x;
    x.is_write = 1'b0;
    x.size     = MSIZE4;
    x.addr     = addr;
    x.strobe   = '0;
    x.data     = '0;
    return x;
  endfunction

  // Data requests pass through; any enabled byte lane makes it a store
  function automatic xact_t dbus_to_xact(input dbus_req_t r);
    xact_t x;
    x.is_write = |r.strobe;
    x.size     = r.size;
    x.addr     = r.addr;
    x.strobe   = r.strobe;
    x.data     = r.data;
    return x;
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// mem_bridge_if: CPU-side ibus/dbus channels and memory-side cbus channel.
// slave = bridge view, master = requester/memory view.
interface mem_bridge_if;
  import mem_bridge_pkg::*;

  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport slave (
    input  ireq, dreq, cresp,
    output iresp, dresp, creq
  );

  modport master (
    output ireq, dreq, cresp,
    input  iresp, dresp, creq
  );
endinterface

// File: rtl/mem_bridge_rr_arbiter.sv
// bus_rr_arbiter: two-requester round-robin arbiter. When both request, the
// requester not granted last wins; a lone requester wins at once. The
// last-grant state only advances when the caller accepts the grant.
module bus_rr_arbiter
  import mem_bridge_pkg::*;
#(
  parameter bit FIRST_GRANT_DBUS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req_ibus,
  input  logic       i_req_dbus,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_last_dbus;

  // Grant selection from current requests and last-grant history
  always_comb begin
    o_grant = GNT_NONE;
    if (i_req_dbus && i_req_ibus) begin
      o_grant = r_last_dbus ? GNT_IBUS : GNT_DBUS;
    end else if (i_req_dbus) begin
      o_grant = GNT_DBUS;
    end else if (i_req_ibus) begin
      o_grant = GNT_IBUS;
    end
  end

  // Remember who was granted; reset value hands the first tie to FIRST_GRANT_DBUS
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_dbus <= ~FIRST_GRANT_DBUS;
    end else if (i_advance && (o_grant != GNT_NONE)) begin
      r_last_dbus <= o_grant[1];
    end
  end

endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: arbitrates an instruction-fetch port (ibus) and a load/store port
// (dbus) onto a single-beat memory bus (cbus). One transaction at a time:
// IDLE (grant+latch) -> BUSY (drive cbus until ready&last) -> RESP (1-cycle ok).
// Build option: MEM_BRIDGE_IBUS_PORT_EN enables the ibus port and the round-robin
// arbiter; without it only dbus is served and iresp is tied to zero.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter bit FIRST_GRANT_DBUS = 1'b1
) (
  input logic         clk,
  input logic         reset,
  mem_bridge_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] w_grant;
  logic       w_launch;
  logic       w_mem_done;
  xact_t      w_xact_sel;
  xact_t      r_xact;
  logic       r_grant_dbus;
  word_t      r_rdata;
  cbus_req_t  w_creq;
  dbus_resp_t w_dresp;
  ibus_resp_t w_iresp;

`ifdef MEM_BRIDGE_IBUS_PORT_EN
  bus_rr_arbiter #(
    .FIRST_GRANT_DBUS (FIRST_GRANT_DBUS)
  ) u_arb (
    .clk        (clk),
    .rst        (reset),
    .i_req_ibus (bus.ireq.valid),
    .i_req_dbus (bus.dreq.valid),
    .i_advance  (w_launch),
    .o_grant    (w_grant)
  );

  // Normalise the winning request into the common transaction format
  always_comb begin
    w_xact_sel = w_grant[1] ? dbus_to_xact(bus.dreq) : ibus_to_xact(bus.ireq.addr);
  end
`else
  logic w_unused_ibus;

  assign w_grant       = {bus.dreq.valid, 1'b0};
  assign w_xact_sel    = dbus_to_xact(bus.dreq);
  assign w_unused_ibus = FIRST_GRANT_DBUS ^ (^bus.ireq);
`endif

  assign w_launch   = (r_state == IDLE) && (w_grant != GNT_NONE);
  assign w_mem_done = (r_state == BUSY) && bus.cresp.ready && bus.cresp.last;

  // Bridge state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and bus outputs; cbus is driven only from the latched transaction
  always_comb begin
    w_state_nxt     = r_state;
    w_creq          = '0;
    w_dresp         = '0;
    w_iresp         = '0;
    w_creq.is_write = r_xact.is_write;
    w_creq.size     = r_xact.size;
    w_creq.addr     = r_xact.addr;
    w_creq.strobe   = r_xact.strobe;
    w_creq.data     = r_xact.data;
    w_creq.len      = MLEN1;
    w_creq.burst    = AXI_BURST_FIXED;
    w_dresp.data    = r_rdata;
`ifdef MEM_BRIDGE_IBUS_PORT_EN
    w_iresp.data    = r_xact.addr[2] ? r_rdata[63:32] : r_rdata[31:0];
`endif
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_creq.valid = 1'b1;
        if (w_mem_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
        if (r_grant_dbus) begin
          w_dresp.addr_ok = 1'b1;
          w_dresp.data_ok = 1'b1;
        end
`ifdef MEM_BRIDGE_IBUS_PORT_EN
        else begin
          w_iresp.addr_ok = 1'b1;
          w_iresp.data_ok = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Latch the granted request in IDLE and capture read data on the final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xact       <= '0;
      r_grant_dbus <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_launch) begin
        r_xact       <= w_xact_sel;
        r_grant_dbus <= w_grant[1];
      end
      if (w_mem_done) begin
        r_rdata <= bus.cresp.data;
      end
    end
  end

  assign bus.creq  = w_creq;
  assign bus.dresp = w_dresp;
  assign bus.iresp = w_iresp;

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter FIRST_GRANT_DBUS, default 1, meaning the port that wins the first tie after reset (1=dbus, 0=ibus).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ireq  input  ibus_req_t  instruction fetch request.
REQ-005 SHALL have port iresp  output  ibus_resp_t  instruction fetch response.
REQ-006 SHALL have port dreq  input  dbus_req_t  data load/store request.
REQ-007 SHALL have port dresp  output  dbus_resp_t  data response.
REQ-008 SHALL have port creq  output  cbus_req_t  single-beat memory transaction.
REQ-009 SHALL have port cresp  input  cbus_resp_t  memory response.

Function
REQ-010 SHALL implement states IDLE, BUSY, RESP; reset state IDLE.
REQ-011 IDLE: if any enabled request valid, SHALL grant one port, latch its request into an internal register, record the grant, go to BUSY next cycle; otherwise stay in IDLE.
REQ-012 Arbitration SHALL be round-robin: when both valid, the port not granted last wins; the first tie after reset goes to the FIRST_GRANT_DBUS port; a lone valid requester wins immediately.
REQ-013 BUSY: creq.valid=1 driven only from the latched register; creq.len=MLEN1, creq.burst=AXI_BURST_FIXED; is_write = |strobe.
REQ-014 Ibus grant SHALL map to size=MSIZE4, strobe=0, data=0, is_write=0, addr=ireq.addr.
REQ-015 Dbus grant SHALL pass addr, size, strobe, data unchanged.
REQ-016 BUSY: on cresp.ready && cresp.last SHALL capture cresp.data and go to RESP; cresp.ready without last SHALL be ignored; creq held stable until then.
REQ-017 RESP: SHALL assert addr_ok=data_ok=1 on the granted port only, for exactly one cycle, then return to IDLE; creq.valid=0 in RESP and IDLE.
REQ-018 iresp.data SHALL equal captured data[63:32] if latched addr[2]=1, else data[31:0]; dresp.data SHALL equal full captured word.
REQ-019 Non-granted port SHALL see addr_ok=data_ok=0 throughout; its request waits.
REQ-020 Minimum latency: valid in cycle N (IDLE), creq.valid in N+1, ready&last in N+1 -> ok in N+2.
REQ-021 Requester changes to inputs after grant SHALL NOT affect the in-flight transaction.
REQ-022 A requester still valid in the IDLE cycle after its RESP SHALL be treated as a new request.

Reset
REQ-023 Reset SHALL asynchronously force IDLE, creq.valid=0, all ok flags 0, latched register and captured data 0, last-grant to the state giving FIRST_GRANT_DBUS priority.
REQ-024 Reset asserted in BUSY SHALL abandon the transaction; a cresp.ready arriving after reset release in IDLE SHALL be ignored.

Configuration
REQ-025 Macro MEM_BRIDGE_IBUS_PORT_EN: when defined, ibus port arbitrated as above; when undefined, ireq ignored, iresp constant 0, dbus always granted, arbitration logic removed.

Structure
REQ-026 dbus/ibus/cbus types, msize_t, mlen_t, axi_burst_type_t SHALL come from the shared common package; the bridge state enum SHALL be local to the module.
REQ-027 Round-robin selection SHALL be a sub-module bus_rr_arbiter (two request inputs, last-grant state, one-hot grant output).

Verification
REQ-028 Dbus read addr=0x8000_0010, size MSIZE8, strobe 0, memory ready&last first BUSY cycle with data 0x1122334455667788 -> creq.is_write=0, dresp ok at N+2, dresp.data=0x1122334455667788.
REQ-029 Ibus fetch addr=0x8000_0004, memory data 0xAAAABBBB_CCCCDDDD -> creq.size=MSIZE4, strobe 0, iresp.data=0xAAAABBBB.
REQ-030 Dbus store addr=0x8000_01f2, strobe 8'b0000_0100, data 0x00cd0000 -> creq.is_write=1, strobe/data unchanged, dresp ok one cycle.
REQ-031 Both valid continuously after reset, FIRST_GRANT_DBUS=1 -> grants dbus, ibus, dbus, ibus; ready without last for 3 cycles holds BUSY and creq stable.
REQ-032 Reset asserted mid-BUSY -> creq.valid=0 same cycle asynchronously, no ok pulse; next request completes normally.
REQ-033 MEM_BRIDGE_IBUS_PORT_EN undefined, ireq.valid=1 -> creq.valid never asserted for it, iresp stays 0.
